// File: rtl/pc_branch_unit.sv
// ---------------------------------------------------------------------------
// pc_branch_unit
//   Program counter and branch resolver for one core. The control unit issues
//   increment / jump / halt (and optionally call / return) commands; this
//   block resolves conditional jumps against the Z flag and drives the
//   instruction-memory address.
//
//   Optional feature macro: CALL_STACK_EN
//     defined   -> STACK_DEPTH x ADDR_WIDTH return stack, callEn/retEn active,
//                  stackErr reports (sticky) overflow/underflow.
//     undefined -> callEn/retEn ignored, stackErr tied low, no stack storage.
//
// Ports
//   clk          in   rising-edge clock
//   rstN         in   asynchronous active-low reset
//   start        in   leave IDLE/HALT, begin fetching at RESET_ADDR
//   zFlag        in   Z flag from the zero register (registered upstream)
//   incEn        in   PC <= PC+1
//   jmpEn        in   jump request
//   jmpCond      in   00 always, 01 if Z=1, 10 if Z=0, 11 never
//   jmpAddr      in   jump target
//   halt         in   stop fetching
//   callEn       in   call: push PC+1, jump to jmpAddr
//   retEn        in   return: pop into PC
//   pcOut        out  current instruction address
//   branchTaken  out  1-cycle pulse aligned with a taken jump/call/ret
//   running      out  high while in RUN
//   stackErr     out  sticky stack overflow/underflow
// ---------------------------------------------------------------------------
module pc_branch_unit #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = {ADDR_WIDTH{1'b0}},
  parameter int                    STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic                  zFlag,
  input  logic                  incEn,
  input  logic                  jmpEn,
  input  logic [1:0]            jmpCond,
  input  logic [ADDR_WIDTH-1:0] jmpAddr,
  input  logic                  halt,
  input  logic                  callEn,
  input  logic                  retEn,
  output logic [ADDR_WIDTH-1:0] pcOut,
  output logic                  branchTaken,
  output logic                  running,
  output logic                  stackErr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_r;
  state_t                state_nxt_s;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic [ADDR_WIDTH-1:0] pc_nxt_s;
  logic [ADDR_WIDTH-1:0] pc_inc_s;
  logic                  branch_r;
  logic                  branch_nxt_s;
  logic                  running_r;
  logic                  jump_taken_s;

  // PC+1 wraps naturally at 2^ADDR_WIDTH
  assign pc_inc_s = pc_r + PC_ONE;

  // Resolve jump condition against Z sampled at this edge
  always_comb begin
    jump_taken_s = 1'b0;
    case (jmpCond)
      2'b00:   jump_taken_s = 1'b1;
      2'b01:   jump_taken_s = zFlag;
      2'b10:   jump_taken_s = ~zFlag;
      2'b11:   jump_taken_s = 1'b0;
      default: jump_taken_s = 1'b0;
    endcase
  end

`ifdef CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_ONE  = {{(SP_W-1){1'b0}}, 1'b1};
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [ADDR_WIDTH-1:0] stack_r [STACK_DEPTH];
  logic [SP_W-1:0]       sp_r;
  logic [SP_W-1:0]       sp_nxt_s;
  logic [SP_W-1:0]       sp_dec_s;
  logic                  push_s;
  logic                  err_r;
  logic                  err_nxt_s;

  assign sp_dec_s = sp_r - SP_ONE;

  // Next-state / next-PC decision, stack variant
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    branch_nxt_s = 1'b0;
    sp_nxt_s     = sp_r;
    push_s       = 1'b0;
    err_nxt_s    = err_r;
    case (state_r)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_nxt_s = ST_RUN;
          pc_nxt_s    = RESET_ADDR;
          sp_nxt_s    = {SP_W{1'b0}};
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_nxt_s = ST_HALT;
        end else if (retEn) begin
          if (sp_r == {SP_W{1'b0}}) begin
            // Underflow: stack untouched, advance like an increment
            pc_nxt_s  = pc_inc_s;
            err_nxt_s = 1'b1;
          end else begin
            pc_nxt_s     = stack_r[sp_dec_s[IDX_W-1:0]];
            sp_nxt_s     = sp_dec_s;
            branch_nxt_s = 1'b1;
          end
        end else if (callEn) begin
          if (sp_r == SP_FULL) begin
            // Overflow: stack untouched, advance like an increment
            pc_nxt_s  = pc_inc_s;
            err_nxt_s = 1'b1;
          end else begin
            push_s       = 1'b1;
            pc_nxt_s     = jmpAddr;
            sp_nxt_s     = sp_r + SP_ONE;
            branch_nxt_s = 1'b1;
          end
        end else if (jmpEn) begin
          if (jump_taken_s) begin
            pc_nxt_s     = jmpAddr;
            branch_nxt_s = 1'b1;
          end else begin
            pc_nxt_s = pc_inc_s;
          end
        end else if (incEn) begin
          pc_nxt_s = pc_inc_s;
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        pc_nxt_s    = RESET_ADDR;
      end
    endcase
  end

  // Stack pointer and sticky error flag
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sp_r  <= {SP_W{1'b0}};
      err_r <= 1'b0;
    end else begin
      sp_r  <= sp_nxt_s;
      err_r <= err_nxt_s;
    end
  end

  // Return-stack storage; pushes write the wrapped return address
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_r[i] <= {ADDR_WIDTH{1'b0}};
      end
    end else if (push_s) begin
      stack_r[sp_r[IDX_W-1:0]] <= pc_inc_s;
    end
  end

  assign stackErr = err_r;

`else
  logic unused_cmd_s;

  // Stack commands have no effect in this build
  assign unused_cmd_s = callEn | retEn | (STACK_DEPTH < 1);

  // Next-state / next-PC decision, no-stack variant
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    branch_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_nxt_s = ST_RUN;
          pc_nxt_s    = RESET_ADDR;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_nxt_s = ST_HALT;
        end else if (jmpEn) begin
          if (jump_taken_s) begin
            pc_nxt_s     = jmpAddr;
            branch_nxt_s = 1'b1;
          end else begin
            pc_nxt_s = pc_inc_s;
          end
        end else if (incEn) begin
          pc_nxt_s = pc_inc_s;
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        pc_nxt_s    = RESET_ADDR;
      end
    endcase
  end

  assign stackErr = 1'b0;
`endif

  // State, PC and registered status outputs
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_r   <= ST_IDLE;
      pc_r      <= RESET_ADDR;
      branch_r  <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pc_r      <= pc_nxt_s;
      branch_r  <= branch_nxt_s;
      running_r <= (state_nxt_s == ST_RUN);
    end
  end

  assign pcOut       = pc_r;
  assign branchTaken = branch_r;
  assign running     = running_r;

endmodule

// File: tb/tb_pc_branch_unit.sv
module tb_pc_branch_unit;

  localparam int AW = 8;
`ifdef CALL_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstN;
  logic          start, zFlag, incEn, jmpEn, halt, callEn, retEn;
  logic [1:0]    jmpCond;
  logic [AW-1:0] jmpAddr;
  logic [AW-1:0] pcOut;
  logic          branchTaken, running, stackErr;

  int n_checks = 0;
  int n_fail   = 0;

  pc_branch_unit #(.ADDR_WIDTH(AW), .RESET_ADDR(8'h00), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rstN(rstN), .start(start), .zFlag(zFlag), .incEn(incEn),
    .jmpEn(jmpEn), .jmpCond(jmpCond), .jmpAddr(jmpAddr), .halt(halt),
    .callEn(callEn), .retEn(retEn), .pcOut(pcOut), .branchTaken(branchTaken),
    .running(running), .stackErr(stackErr)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  int m_mode;          // 0 idle, 1 run, 2 halted
  int m_pc;
  int m_stack[$];
  bit m_bt;
  bit m_err;

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_bt = 0; m_err = 0;
    m_stack.delete();
  endtask

  task automatic model_step();
    bit taken;
    m_bt = 0;
    if (m_mode != 1) begin
      if (start) begin
        m_mode = 1; m_pc = 0; m_stack.delete();
      end
    end else if (halt) begin
      m_mode = 2;
    end else if (STACK_EN && retEn) begin
      if (m_stack.size() == 0) begin m_err = 1; m_pc = (m_pc + 1) % 256; end
      else begin m_pc = m_stack.pop_back(); m_bt = 1; end
    end else if (STACK_EN && callEn) begin
      if (m_stack.size() == DEPTH) begin m_err = 1; m_pc = (m_pc + 1) % 256; end
      else begin m_stack.push_back((m_pc + 1) % 256); m_pc = int'(jmpAddr); m_bt = 1; end
    end else if (jmpEn) begin
      taken = (jmpCond == 2'd0) || (jmpCond == 2'd1 && zFlag) || (jmpCond == 2'd2 && !zFlag);
      if (taken) begin m_pc = int'(jmpAddr); m_bt = 1; end
      else m_pc = (m_pc + 1) % 256;
    end else if (incEn) begin
      m_pc = (m_pc + 1) % 256;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 0; zFlag = 0; incEn = 0; jmpEn = 0; jmpCond = 2'b00;
    jmpAddr = 8'h00; halt = 0; callEn = 0; retEn = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstN = 1'b0;
    #3;
    rstN = 1'b1;
    tick();
  endtask

  task automatic cmd_start();
    idle_inputs(); start = 1; tick(); idle_inputs();
  endtask

  task automatic cmd_jump(input logic [7:0] a);
    idle_inputs(); jmpEn = 1; jmpCond = 2'b00; jmpAddr = a; tick(); idle_inputs();
  endtask

  typedef struct {
    logic       start, z, inc, jmp, hlt;
    logic [1:0] cond;
    logic [7:0] addr;
    logic [7:0] exp_pc;
    logic       exp_bt, exp_run;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic s, input logic z, input logic i, input logic j,
                              input logic h, input logic [1:0] c, input logic [7:0] a,
                              input logic [7:0] epc, input logic ebt, input logic erun);
    vec_t v;
    v.start = s; v.z = z; v.inc = i; v.jmp = j; v.hlt = h; v.cond = c; v.addr = a;
    v.exp_pc = epc; v.exp_bt = ebt; v.exp_run = erun;
    return v;
  endfunction

  initial begin
    // start z  inc jmp hlt cond   addr   pc     bt  run
    tbl[0]  = mk(0, 0, 1, 0, 0, 2'b00, 8'h00, 8'h01, 0, 1);
    tbl[1]  = mk(0, 0, 1, 0, 0, 2'b00, 8'h00, 8'h02, 0, 1);
    tbl[2]  = mk(0, 0, 0, 1, 0, 2'b00, 8'h40, 8'h40, 1, 1);
    tbl[3]  = mk(0, 1, 0, 1, 0, 2'b01, 8'h80, 8'h80, 1, 1);
    tbl[4]  = mk(0, 0, 0, 1, 0, 2'b01, 8'h10, 8'h81, 0, 1);
    tbl[5]  = mk(0, 0, 0, 1, 0, 2'b10, 8'h10, 8'h10, 1, 1);
    tbl[6]  = mk(0, 1, 0, 1, 0, 2'b10, 8'h50, 8'h11, 0, 1);
    tbl[7]  = mk(0, 0, 0, 1, 0, 2'b11, 8'h50, 8'h12, 0, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0, 2'b00, 8'h00, 8'h12, 0, 1);
    tbl[9]  = mk(0, 0, 1, 1, 0, 2'b00, 8'hFE, 8'hFE, 1, 1);
    tbl[10] = mk(0, 0, 1, 0, 0, 2'b00, 8'h00, 8'hFF, 0, 1);
    tbl[11] = mk(0, 0, 1, 0, 0, 2'b00, 8'h00, 8'h00, 0, 1);
    tbl[12] = mk(0, 0, 0, 1, 1, 2'b00, 8'h33, 8'h00, 0, 0);
    tbl[13] = mk(0, 0, 1, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0);
    tbl[14] = mk(0, 0, 0, 1, 0, 2'b00, 8'h33, 8'h00, 0, 0);
    tbl[15] = mk(1, 0, 1, 0, 0, 2'b00, 8'h00, 8'h00, 0, 1);

    idle_inputs();
    rstN = 1'b0;
    #2;
    check("reset_pc", int'(pcOut), 0);
    check("reset_running", int'(running), 0);
    check("reset_bt", int'(branchTaken), 0);
    check("reset_stackerr", int'(stackErr), 0);
    #4 rstN = 1'b1;
    tick();

    // IDLE ignores commands
    incEn = 1; jmpEn = 1; jmpAddr = 8'h77; tick(); idle_inputs();
    check("idle_ignores_pc", int'(pcOut), 0);
    check("idle_running", int'(running), 0);

    cmd_start();
    check("start_running", int'(running), 1);
    check("start_pc", int'(pcOut), 0);

    // Table-driven vectors
    for (int k = 0; k < 16; k++) begin
      idle_inputs();
      start = tbl[k].start; zFlag = tbl[k].z; incEn = tbl[k].inc; jmpEn = tbl[k].jmp;
      halt = tbl[k].hlt; jmpCond = tbl[k].cond; jmpAddr = tbl[k].addr;
      tick();
      check($sformatf("tbl%0d_pc", k), int'(pcOut), int'(tbl[k].exp_pc));
      check($sformatf("tbl%0d_bt", k), int'(branchTaken), int'(tbl[k].exp_bt));
      check($sformatf("tbl%0d_run", k), int'(running), int'(tbl[k].exp_run));
    end
    idle_inputs();

    // Reset mid-RUN at pc 5 aborts immediately
    cmd_jump(8'h05);
    check("pre_reset_pc", int'(pcOut), 5);
    incEn = 1;
    rstN = 1'b0;
    #1;
    check("midrun_reset_pc", int'(pcOut), 0);
    check("midrun_reset_running", int'(running), 0);
    #2 rstN = 1'b1;
    idle_inputs();
    tick();
    check("after_reset_idle_pc", int'(pcOut), 0);
    cmd_start();
    check("restart_running", int'(running), 1);
    check("restart_pc", int'(pcOut), 0);

    // Wrap from 254
    cmd_jump(8'hFE);
    incEn = 1; tick();
    check("wrap_255", int'(pcOut), 255);
    tick();
    check("wrap_0", int'(pcOut), 0);
    check("wrap_bt", int'(branchTaken), 0);
    tick();
    check("wrap_1", int'(pcOut), 1);
    idle_inputs();

    // Conditional jump on Z, pulse lasts one cycle
    zFlag = 1; jmpEn = 1; jmpCond = 2'b01; jmpAddr = 8'h40; tick(); idle_inputs();
    check("zjmp_pc", int'(pcOut), 8'h40);
    check("zjmp_bt", int'(branchTaken), 1);
    tick();
    check("zjmp_bt_pulse_end", int'(branchTaken), 0);
    zFlag = 1; jmpEn = 1; jmpCond = 2'b10; jmpAddr = 8'h99; tick(); idle_inputs();
    check("nzjmp_pc", int'(pcOut), 8'h41);
    check("nzjmp_bt", int'(branchTaken), 0);

    // halt beats jump, HALT ignores commands, start reloads
    cmd_jump(8'h07);
    halt = 1; jmpEn = 1; jmpAddr = 8'h20; tick(); idle_inputs();
    check("halt_pc", int'(pcOut), 7);
    check("halt_running", int'(running), 0);
    incEn = 1; tick(); idle_inputs();
    check("halt_inc_ignored", int'(pcOut), 7);
    cmd_start();
    check("halt_start_pc", int'(pcOut), 0);
    check("halt_start_running", int'(running), 1);

`ifdef CALL_STACK_EN
    cmd_jump(8'h03);
    callEn = 1; jmpAddr = 8'h20; tick(); idle_inputs();
    check("call1_pc", int'(pcOut), 8'h20);
    check("call1_bt", int'(branchTaken), 1);
    callEn = 1; jmpAddr = 8'h30; tick(); idle_inputs();
    check("call2_pc", int'(pcOut), 8'h30);
    retEn = 1; tick(); idle_inputs();
    check("ret1_pc", int'(pcOut), 8'h21);
    check("ret1_bt", int'(branchTaken), 1);
    retEn = 1; tick(); idle_inputs();
    check("ret2_pc", int'(pcOut), 4);
    check("ret_no_err", int'(stackErr), 0);

    cmd_jump(8'h09);
    retEn = 1; tick(); idle_inputs();
    check("underflow_pc", int'(pcOut), 10);
    check("underflow_bt", int'(branchTaken), 0);
    check("underflow_err", int'(stackErr), 1);
    incEn = 1; tick(); tick(); idle_inputs();
    check("err_sticky", int'(stackErr), 1);
    do_reset();
    check("err_cleared_by_reset", int'(stackErr), 0);
    cmd_start();
`else
    cmd_jump(8'h03);
    callEn = 1; incEn = 1; jmpAddr = 8'h20; tick(); idle_inputs();
    check("call_ignored_pc", int'(pcOut), 4);
    check("call_ignored_bt", int'(branchTaken), 0);
    retEn = 1; tick(); idle_inputs();
    check("ret_ignored_pc", int'(pcOut), 4);
    check("no_stack_err", int'(stackErr), 0);
`endif

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      start   = ($urandom_range(0, 7) == 0);
      halt    = ($urandom_range(0, 15) == 0);
      incEn   = $urandom_range(0, 1);
      jmpEn   = ($urandom_range(0, 2) == 0);
      jmpCond = 2'($urandom_range(0, 3));
      jmpAddr = 8'($urandom_range(0, 255));
      zFlag   = $urandom_range(0, 1);
      callEn  = ($urandom_range(0, 5) == 0);
      retEn   = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rstN = 1'b0;
        model_reset();
        #1;
        check("rnd_async_reset_pc", int'(pcOut), m_pc);
        check("rnd_async_reset_run", int'(running), 0);
        #1 rstN = 1'b1;
      end
      model_step();
      tick();
      check("rnd_pc", int'(pcOut), m_pc);
      check("rnd_bt", int'(branchTaken), int'(m_bt));
      check("rnd_run", int'(running), int'(m_mode == 1));
      check("rnd_err", int'(stackErr), int'(m_err));
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
